// File: rtl/right_shift_seq_if.sv
// right_shift_seq_if: request/response bundle for the multi-cycle right shifter.
//   start        - request, accepted on an edge where start && ready
//   data_in      - operand (WIDTH bits)
//   shamt        - shift amount (SHAMT_W bits)
//   arith        - 1 = sign fill, 0 = zero fill
//   ready        - shifter idle and able to accept
//   result_valid - one-cycle pulse when result is fresh
//   result       - shifted value, held until the next accept
//   sticky       - OR of all shifted-out bits (0 unless RSHIFT_STICKY_EN)
// Modports: master = requester side, slave = shifter side.
interface right_shift_seq_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic               ready;
  logic               result_valid;
  logic [WIDTH-1:0]   result;
  logic               sticky;

  modport master (
    output start, data_in, shamt, arith,
    input  ready, result_valid, result, sticky
  );

  modport slave (
    input  start, data_in, shamt, arith,
    output ready, result_valid, result, sticky
  );
endinterface

// File: rtl/right_shift_seq.sv
// right_shift_seq: multi-cycle logical/arithmetic right shifter (SRL/SRA).
// One binary stage per cycle, MSB stage first (16, 8, 4, 2, 1 for WIDTH=32).
// Fixed latency: accept edge to result_valid is SHAMT_W edges regardless of shamt.
// Ports:
//   clock   - rising-edge clock
//   reset_n - synchronous active-low reset
//   bus     - right_shift_seq_if.slave (start/data_in/shamt/arith in,
//             ready/result_valid/result/sticky out)
// Optional feature: define RSHIFT_STICKY_EN to generate the sticky
// (shifted-out OR) logic; otherwise sticky is tied to 0.
// WIDTH must equal 2**SHAMT_W.
module right_shift_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  right_shift_seq_if.slave  bus
);

  localparam int KW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [KW-1:0]      k_q;
  logic               arith_q;
  logic               sign_q;

  logic               ready;
  logic               result_valid;
  logic               accept;
  logic               last_stage;
  logic               fill;
  logic [SHAMT_W:0]   stage_amt;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   acc_d;

  assign accept     = (state_q == IDLE) && bus.start;
  assign last_stage = (k_q == '0);

  // Sign captured once at accept, so every stage fills with the original MSB.
  assign fill = arith_q & sign_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ready        = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_stage) state_d = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    stage_amt = (SHAMT_W+1)'(1) << k_q;
    fill_mask = ~({WIDTH{1'b1}} >> stage_amt);
    shifted   = (acc_q >> stage_amt) | (fill ? fill_mask : '0);
    acc_d     = shamt_q[k_q] ? shifted : acc_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q    <= '0;
      result_q <= '0;
      shamt_q  <= '0;
      k_q      <= '0;
      arith_q  <= 1'b0;
      sign_q   <= 1'b0;
    end else if (accept) begin
      acc_q   <= bus.data_in;
      shamt_q <= bus.shamt;
      arith_q <= bus.arith;
      sign_q  <= bus.data_in[WIDTH-1];
      k_q     <= KW'(SHAMT_W-1);
    end else if (state_q == SHIFT) begin
      acc_q <= acc_d;
      k_q   <= k_q - KW'(1);
      if (last_stage) result_q <= acc_d;
    end
  end

  assign bus.ready        = ready;
  assign bus.result_valid = result_valid;
  assign bus.result       = result_q;

`ifdef RSHIFT_STICKY_EN
  // Accumulator runs during SHIFT; the visible flag is loaded together with
  // result so both hold until the next completed operation.
  logic [WIDTH-1:0] discard;
  logic             sticky_acc_q;
  logic             sticky_acc_d;
  logic             sticky_q;

  always_comb begin
    discard      = acc_q & ~({WIDTH{1'b1}} << stage_amt);
    sticky_acc_d = sticky_acc_q | (shamt_q[k_q] & (|discard));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sticky_acc_q <= 1'b0;
      sticky_q     <= 1'b0;
    end else if (accept) begin
      sticky_acc_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      sticky_acc_q <= sticky_acc_d;
      if (last_stage) sticky_q <= sticky_acc_d;
    end
  end

  assign bus.sticky = sticky_q;
`else
  assign bus.sticky = 1'b0;
`endif

endmodule

// File: tb/tb_right_shift_seq.sv
// tb_right_shift_seq: randomized self-checking bench for right_shift_seq.
// Reference model computes the shift directly with >> / >>> and a mask for
// the shifted-out bits; sticky expectations follow RSHIFT_STICKY_EN.
module tb_right_shift_seq;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic clock;
  logic reset_n;

  right_shift_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  right_shift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [WIDTH-1:0] last_result;
  logic             last_sticky;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input int unsigned s,
                                                 input logic a);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    if (a) return WIDTH'(sd >>> s);
    return d >> s;
  endfunction

  function automatic logic ref_sticky(input logic [WIDTH-1:0] d,
                                      input int unsigned s);
    logic [63:0] m;
    m = (64'd1 << s) - 64'd1;
    return |({32'd0, d} & m);
  endfunction

  function automatic logic exp_sticky(input logic [WIDTH-1:0] d,
                                      input int unsigned s);
`ifdef RSHIFT_STICKY_EN
    return ref_sticky(d, s);
`else
    return (d == '0) && (s == 32'hFFFF_FFFF);
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full operation from IDLE: accept, SHAMT_W busy edges, DONE, back to IDLE.
  task automatic run_op(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                        input logic a);
    logic [WIDTH-1:0] er;
    logic             es;
    er = ref_shift(d, s, a);
    es = exp_sticky(d, s);
    check("idle_ready", WIDTH'(bus.ready), WIDTH'(1));
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.shamt   = s;
    bus.arith   = a;
    tick();                                   // E0
    for (int i = 0; i < SHAMT_W; i++) begin
      // inputs after accept must be ignored, including start
      bus.start   = 1'($urandom);
      bus.data_in = $urandom;
      bus.shamt   = SHAMT_W'($urandom);
      bus.arith   = 1'($urandom);
      check("busy_ready", WIDTH'(bus.ready), WIDTH'(0));
      check("busy_valid", WIDTH'(bus.result_valid), WIDTH'(0));
      check("busy_hold", bus.result, last_result);
      check("busy_sticky", WIDTH'(bus.sticky), WIDTH'(last_sticky));
      tick();                                 // E1..E(SHAMT_W)
    end
    check("done_valid", WIDTH'(bus.result_valid), WIDTH'(1));
    check("done_ready", WIDTH'(bus.ready), WIDTH'(0));
    check("result", bus.result, er);
    check("sticky", WIDTH'(bus.sticky), WIDTH'(es));
    tick();
    bus.start = 1'b0;
    check("post_valid", WIDTH'(bus.result_valid), WIDTH'(0));
    check("post_ready", WIDTH'(bus.ready), WIDTH'(1));
    check("post_hold", bus.result, er);
    check("post_sticky", WIDTH'(bus.sticky), WIDTH'(es));
    last_result = er;
    last_sticky = es;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] opa, opb;
    logic [SHAMT_W-1:0] sb;
    logic ab;
    last_result = '0;
    last_sticky = 1'b0;

    // Reset held 2 cycles with start high: nothing starts.
    reset_n     = 1'b0;
    bus.start   = 1'b1;
    bus.data_in = 32'hDEAD_BEEF;
    bus.shamt   = 5'd3;
    bus.arith   = 1'b1;
    tick();
    tick();
    check("rst_ready", WIDTH'(bus.ready), WIDTH'(1));
    check("rst_valid", WIDTH'(bus.result_valid), WIDTH'(0));
    check("rst_result", bus.result, '0);
    check("rst_sticky", WIDTH'(bus.sticky), '0);
    bus.start = 1'b0;
    reset_n   = 1'b1;
    tick();
    check("rst_idle_ready", WIDTH'(bus.ready), WIDTH'(1));
    check("rst_idle_valid", WIDTH'(bus.result_valid), WIDTH'(0));

    // Directed cases
    run_op(32'h8000_0000, 5'd4, 1'b0);
    check("srl_dir", last_result, 32'h0800_0000);
    run_op(32'hF000_0010, 5'd31, 1'b1);
    check("sra31_dir", last_result, 32'hFFFF_FFFF);
    run_op(32'hF000_0010, 5'd31, 1'b0);
    check("srl31_dir", last_result, 32'h0000_0001);
    run_op(32'h1234_5678, 5'd0, 1'b1);
    check("sh0_dir", last_result, 32'h1234_5678);
    run_op(32'h7FFF_FFFF, 5'd31, 1'b1);
    run_op(32'h8000_0000, 5'd31, 1'b1);

    // start held high; operand changes during SHIFT; next accept after DONE.
    opa = 32'hC001_D00D;
    bus.start   = 1'b1;
    bus.data_in = opa;
    bus.shamt   = 5'd12;
    bus.arith   = 1'b1;
    tick();                                   // E0
    for (int i = 0; i < SHAMT_W; i++) begin
      bus.data_in = $urandom;
      tick();
    end
    check("hold_start_valid", WIDTH'(bus.result_valid), WIDTH'(1));
    check("hold_start_res", bus.result, ref_shift(opa, 12, 1'b1));
    opb = $urandom;
    sb  = SHAMT_W'($urandom);
    ab  = 1'($urandom);
    bus.data_in = opb;
    bus.shamt   = sb;
    bus.arith   = ab;
    tick();                                   // DONE -> IDLE
    check("hold_start_idle", WIDTH'(bus.ready), WIDTH'(1));
    tick();                                   // second accept
    check("hold_start_acc", WIDTH'(bus.ready), WIDTH'(0));
    bus.start = 1'b0;
    for (int i = 0; i < SHAMT_W; i++) tick();
    check("hold_start_valid2", WIDTH'(bus.result_valid), WIDTH'(1));
    check("hold_start_res2", bus.result, ref_shift(opb, sb, ab));
    tick();
    last_result = ref_shift(opb, sb, ab);
    last_sticky = exp_sticky(opb, sb);

    // Reset pulsed at E3 of an operation: abandoned, no result_valid.
    bus.start   = 1'b1;
    bus.data_in = 32'hFFFF_0000;
    bus.shamt   = 5'd7;
    bus.arith   = 1'b1;
    tick();                                   // E0
    bus.start = 1'b0;
    tick();                                   // E1
    tick();                                   // E2
    reset_n = 1'b0;
    tick();                                   // E3 (reset)
    reset_n = 1'b1;
    check("midrst_ready", WIDTH'(bus.ready), WIDTH'(1));
    check("midrst_result", bus.result, '0);
    check("midrst_sticky", WIDTH'(bus.sticky), '0);
    for (int i = 0; i < SHAMT_W + 2; i++) begin
      check("midrst_novalid", WIDTH'(bus.result_valid), WIDTH'(0));
      tick();
    end
    last_result = '0;
    last_sticky = 1'b0;
    run_op(32'h0000_0100, 5'd8, 1'b0);
    check("midrst_next", last_result, 32'h0000_0001);

    // Randomized operations, with a few idle cycles between them.
    for (int n = 0; n < 40; n++) begin
      run_op($urandom, SHAMT_W'($urandom), 1'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        check("idle_valid", WIDTH'(bus.result_valid), WIDTH'(0));
        check("idle_hold", bus.result, last_result);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/right_shift_seq.md
Name: right_shift_seq

Overview:
- Multi-cycle logical/arithmetic right shifter for the processor's SRL/SRA datapath.
- Complements the fixed left-by-16 immediate shifter.
- Applies the shift amount one binary stage per cycle, MSB stage first (16, 8, 4, 2, 1 for the default width).
- Accepts work with a ready/start handshake and returns the result with a one-cycle valid pulse to the execute-stage stall logic.

Parameters:
- WIDTH, 32, data width in bits; must equal 2**SHAMT_W.
- SHAMT_W, 5, shift-amount width; also the number of shift stages.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- start  input  1  request; accepted only on an edge where start && ready.
- data_in  input  WIDTH  operand.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- arith  input  1  1 = arithmetic shift (sign fill), 0 = logical shift (zero fill).
- ready  output  1  high in IDLE only.
- result_valid  output  1  high for exactly one cycle, in DONE.
- result  output  WIDTH  shifted value; holds its value until the next accept.
- sticky  output  1  OR of all shifted-out bits (only with the optional feature).

Behaviour:
- Reset (reset_n == 0 at an edge):
  - state = IDLE.
  - ready = 1, result_valid = 0, result = 0, sticky = 0.
  - Internal shamt/arith/accumulator registers are cleared.
  - Reset overrides every other input, including start on the same edge.
- States: IDLE, SHIFT, DONE.
  - SHIFT uses a stage counter k running SHAMT_W-1 down to 0.
- IDLE:
  - ready = 1.
  - On start at edge E0: latch data_in into the accumulator, latch shamt and arith, set k = SHAMT_W-1, go to SHIFT.
  - While start is low: stay in IDLE; result keeps its last value.
- SHIFT, at each edge:
  - If shamt_reg[k] = 1: acc = acc >> 2**k.
  - Vacated MSBs take the fill value: acc[WIDTH-1] latched at E0 if arith_reg, else 0.
  - If shamt_reg[k] = 0: acc is unchanged.
  - Then decrement k. The edge that processes k = 0 moves to DONE and loads result = final acc.
  - Stage edges are E1..E(SHAMT_W).
- Fill rule: the sign bit is captured once at E0 and reused for every stage. Staged SRA therefore equals a single-step SRA.
- DONE (cycle after E(SHAMT_W)):
  - result_valid = 1, ready = 0.
  - The next edge returns to IDLE unconditionally: result_valid = 0, ready = 1.
- Latency:
  - Accept edge to result_valid high is SHAMT_W edges; result_valid is high for one cycle.
  - Minimum issue interval is SHAMT_W+2 edges.
  - Latency is fixed and does not depend on shamt; shamt = 0 still takes the full latency.
- Handshake:
  - start while ready = 0 (SHIFT or DONE) is ignored; nothing is queued.
  - data_in, shamt and arith are sampled only at the accept edge; later changes to them have no effect.
- Reset mid-operation: an in-flight operation is abandoned with no result_valid pulse, and all reset values apply.
- Boundaries:
  - shamt = WIDTH-1 with arith = 1 and negative operand gives all ones.
  - With arith = 0 it gives 0 or 1, depending on data_in[WIDTH-1].
  - shamt values at or above WIDTH cannot occur, because SHAMT_W bits only reach WIDTH-1.

Optional Feature:
- Macro: RSHIFT_STICKY_EN.
- When defined:
  - A sticky register is cleared at accept.
  - At each stage that shifts, sticky |= OR of the 2**k LSBs of acc being discarded.
  - sticky is presented with result and holds with it.
  - Reset clears sticky.
  - Intended for FP/divider rounding.
- When undefined:
  - The sticky output is tied to 0 and no sticky logic is generated.
  - Timing and all other outputs are identical to the defined case.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with start = 1 -> ready = 1, result_valid = 0, result = 0; no operation is started.
- SRL: data_in = 0x80000000, shamt = 4, arith = 0 -> exactly 5 edges later result = 0x08000000 with a single-cycle result_valid; sticky = 0.
- SRA: data_in = 0xF0000010, shamt = 31, arith = 1 -> result = 0xFFFFFFFF. With arith = 0 -> result = 0x00000001; sticky = 1 when the feature is enabled.
- shamt = 0, data_in = 0x12345678 -> result = 0x12345678 after the full 5-edge latency.
- start held high continuously, with data_in changed during SHIFT -> only the first operand is processed; the next accept occurs on the edge after DONE.
- reset_n pulsed low at E3 of an operation -> no result_valid; IDLE next cycle; a following request with 0x00000100, shamt = 8, arith = 0 -> result = 0x00000001.
